// File: rtl/ram_bist_pkg.sv
// Shared types and the test-pattern generator for the SDP RAM self-test.
// The same pat() feeds the write port and the expected-data compare path.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE_INC   = 2'b00;
  localparam logic [1:0] MODE_WALK1 = 2'b01;
  localparam logic [1:0] MODE_CHK   = 2'b10;
  localparam logic [1:0] MODE_ADDR  = 2'b11;

  // Result is masked to data_w bits; callers cast down to their word width.
  function automatic logic [63:0] pat(input logic [1:0]  mode,
                                      input logic [63:0] addr,
                                      input int          data_w,
                                      input logic [63:0] seed);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (64'd1 << data_w) - 64'd1;
    case (mode)
      MODE_INC:   v = seed + addr;
      MODE_WALK1: v = 64'd1 << (addr % 64'(data_w));
      MODE_CHK:   v = addr[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      default:    v = addr;
    endcase
    return v & mask;
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Inferred simple dual-port RAM: write on port A, registered read on port B.
module ram_sdp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clka,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              clkb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    doutb <= mem[addrb];
  end

endmodule

// File: rtl/ram_bist_sdp.sv
// Self-test controller: fills the RAM with a pattern, reads it back and
// compares every word, reporting pass/fail, error count and first bad address.
module ram_bist_sdp
  import ram_bist_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 9,
  parameter int unsigned SEED     = 1,
  parameter int          INJ_ADDR = (2 ** ADDR_W) / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic              inject,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       pass_cnt,
  output logic [ADDR_W-1:0] dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] INJ       = ADDR_W'(INJ_ADDR);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              inject_q, inject_d;
  logic              ok_q, ok_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d;
  logic              cmp_valid_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [DATA_W-1:0] exp_q;

  logic              wea;
  logic [DATA_W-1:0] wr_word, rd_word, dina, doutb;
  logic              start_ok, mismatch;

  assign wr_word = DATA_W'(pat(mode_q, 64'(wr_addr_q), DATA_W, 64'(SEED)));
  assign rd_word = DATA_W'(pat(mode_q, 64'(rd_addr_q), DATA_W, 64'(SEED)));
  assign wea     = (state_q == ST_WRITE);
  assign dina    = wr_word ^ DATA_W'(inject_q && (wr_addr_q == INJ));

  ram_sdp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clka  (clk),
    .wea   (wea),
    .addra (wr_addr_q),
    .dina  (dina),
    .clkb  (clk),
    .addrb (rd_addr_q),
    .doutb (doutb)
  );

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign mismatch = cmp_valid_q && (doutb != exp_q);

  // NOTE: every next-state variable is defaulted first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    inject_d    = inject_q;
    ok_d        = ok_q;
    pass_d      = pass_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_cnt_d  = pass_cnt_q;

    // Compare first so a DRAIN-cycle mismatch is already in ok_d below.
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0)    first_err_d = cmp_addr_q;
      ok_d = 1'b0;
    end

    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_WRITE;
      ST_WRITE: begin
        if (wr_addr_q == LAST_ADDR) state_d = ST_READ;
        else                        wr_addr_d = wr_addr_q + 1'b1;
      end
      ST_READ: begin
        if (rd_addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else                        rd_addr_d = rd_addr_q + 1'b1;
      end
      ST_DRAIN: begin
        state_d    = ST_DONE;
        pass_cnt_d = pass_cnt_q + 16'd1;
        pass_d     = ok_d;
      end
      ST_DONE:  if (start_ok || loop) state_d = ST_WRITE;
      default:  state_d = ST_IDLE;
    endcase

    if (start_ok) begin
      mode_d      = mode;
      inject_d    = inject;
      ok_d        = 1'b1;
      pass_d      = 1'b0;
      err_cnt_d   = '0;
      first_err_d = '0;
      pass_cnt_d  = '0;
    end

    if (state_d != state_q) begin
      wr_addr_d = '0;
      rd_addr_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_INC;
      inject_q    <= 1'b0;
      ok_q        <= 1'b0;
      pass_q      <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_cnt_q  <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      inject_q    <= inject_d;
      ok_q        <= ok_d;
      pass_q      <= pass_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_cnt_q  <= pass_cnt_d;
      cmp_valid_q <= (state_q == ST_READ);
      cmp_addr_q  <= rd_addr_q;
      exp_q       <= rd_word;
    end
  end

  assign busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q && done;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign pass_cnt       = pass_cnt_q;
  assign dbg_rd_addr    = rd_addr_q;
  // RAM output register has no reset; show data only while it is a live read.
  assign dbg_rd_data    = cmp_valid_q ? doutb : '0;

endmodule

// File: tb/tb_ram_bist_sdp.sv
// Randomised bench for ram_bist_sdp against a word-level model of the
// written RAM image, expected pattern and cycle timeline.
module tb_ram_bist_sdp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic loop_a = 1'b0, loop_b = 1'b0;
  logic inject = 1'b0;
  logic [1:0] mode = 2'b00;

  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a, pcnt_a, rdata_a;
  logic [8:0]  ferr_a, raddr_a;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_b, pcnt_b;
  logic [9:0]  ferr_b, raddr_b;
  logic [7:0]  rdata_b;

  always #5 clk = ~clk;

  ram_bist_sdp #(.DATA_W(16), .ADDR_W(9)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .loop(loop_a), .inject(inject),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .first_err_addr(ferr_a),
    .pass_cnt(pcnt_a), .dbg_rd_addr(raddr_a), .dbg_rd_data(rdata_a)
  );

  ram_bist_sdp #(.DATA_W(8), .ADDR_W(10)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .loop(loop_b), .inject(inject),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .first_err_addr(ferr_b),
    .pass_cnt(pcnt_b), .dbg_rd_addr(raddr_b), .dbg_rd_data(rdata_b)
  );

  int sel = 0;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_err, o_pcnt, o_rdata;
  logic [9:0]  o_ferr, o_raddr;

  always_comb begin
    o_busy  = (sel == 0) ? busy_a : busy_b;
    o_done  = (sel == 0) ? done_a : done_b;
    o_pass  = (sel == 0) ? pass_a : pass_b;
    o_err   = (sel == 0) ? err_a  : err_b;
    o_pcnt  = (sel == 0) ? pcnt_a : pcnt_b;
    o_ferr  = (sel == 0) ? 10'(ferr_a)  : ferr_b;
    o_raddr = (sel == 0) ? 10'(raddr_a) : raddr_b;
    o_rdata = (sel == 0) ? rdata_a : 16'(rdata_b);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int depth = 512;
  int dw = 16;
  logic [15:0] wr_mem  [1024];
  logic [15:0] exp_mem [1024];
  int m_err, m_first, m_pcnt;
  bit m_ok;
  bit m_have;

  function automatic logic [15:0] mpat(input int m, input int a, input int w, input int seed);
    longint unsigned v, modulus;
    modulus = 64'd1 << w;
    case (m)
      0:       v = longint'(seed + a);
      1:       v = 64'd1 << (a % w);
      2:       v = (a % 2 == 0) ? 64'h5555 : 64'hAAAA;
      default: v = longint'(a);
    endcase
    return 16'(v % modulus);
  endfunction

  task automatic set_start(input bit v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  task automatic begin_run(input logic [1:0] m, input bit inj, input bit lp);
    mode = m;
    inject = inj;
    loop_a = lp;
    set_start(1'b1);
    m_err = 0; m_first = 0; m_pcnt = 0; m_ok = 1'b1; m_have = 1'b0;
    for (int a = 0; a < depth; a++) begin
      exp_mem[a] = mpat(int'(m), a, dw, 1);
      wr_mem[a]  = exp_mem[a] ^ 16'((inj && a == depth / 2) ? 1 : 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(o_busy),  0);
    check({tag, "_done"},  64'(o_done),  0);
    check({tag, "_pass"},  64'(o_pass),  0);
    check({tag, "_err"},   64'(o_err),   0);
    check({tag, "_pcnt"},  64'(o_pcnt),  0);
    check({tag, "_ferr"},  64'(o_ferr),  0);
    check({tag, "_raddr"}, 64'(o_raddr), 0);
    check({tag, "_rdata"}, 64'(o_rdata), 0);
  endtask

  // Follows one pass cycle by cycle; n=1 is the negedge after the edge that enters WRITE.
  task automatic run_pass(input string tag, input int repulse_at, input int abort_at, input bit fresh);
    int  done_n, tl_bad, rd_bad, k;
    bit  seen, aborted;
    seen = 1'b0; aborted = 1'b0; done_n = 0; tl_bad = 0; rd_bad = 0;
    for (int n = 1; n <= 2 * depth + 16 && !seen && !aborted; n++) begin
      @(negedge clk);
      set_start(n == repulse_at);
      if (n == repulse_at) begin
        mode = ~mode;
        inject = ~inject;
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero({tag, "_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        if (fresh && n == 1) begin
          check({tag, "_clr_err"},  64'(o_err),  0);
          check({tag, "_clr_pcnt"}, 64'(o_pcnt), 0);
          check({tag, "_busy1"},    64'(o_busy), 1);
        end
        if (o_busy !== (n <= 2 * depth + 1)) tl_bad++;
        if (o_done !== (n >= 2 * depth + 2)) tl_bad++;
        k = n - depth - 1;
        if (k >= 0 && k < depth && o_raddr !== 10'(k)) tl_bad++;
        k = n - depth - 2;
        if (k >= 0 && k < depth && o_rdata !== wr_mem[k]) rd_bad++;
        k = n - depth - 3;
        if (k >= 0 && k < depth && wr_mem[k] !== exp_mem[k]) begin
          if (m_err < 65535) m_err++;
          if (!m_have) begin
            m_first = k;
            m_have = 1'b1;
          end
          m_ok = 1'b0;
        end
        if (o_err !== 16'(m_err))   tl_bad++;
        if (o_ferr !== 10'(m_first)) tl_bad++;
        if (o_done === 1'b1) begin
          seen = 1'b1;
          done_n = n;
        end
      end
    end
    if (!aborted) begin
      m_pcnt = (m_pcnt + 1) % 65536;
      check({tag, "_done_cycle"}, 64'(done_n), 64'(2 * depth + 2));
      check({tag, "_timeline"},   64'(tl_bad), 0);
      check({tag, "_rd_stream"},  64'(rd_bad), 0);
      check({tag, "_pass"},       64'(o_pass), 64'(m_ok));
      check({tag, "_err_cnt"},    64'(o_err),  64'(m_err));
      check({tag, "_first_err"},  64'(o_ferr), 64'(m_first));
      check({tag, "_pass_cnt"},   64'(o_pcnt), 64'(m_pcnt));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] rm;
    bit         ri;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Incrementing pattern, clean pass
    begin_run(2'b00, 1'b0, 1'b0);
    run_pass("inc", 0, 0, 1'b1);

    // Checkerboard with injected fault at DEPTH/2
    begin_run(2'b10, 1'b1, 1'b0);
    run_pass("chk_inj", 0, 0, 1'b1);

    // Walking ones, injected, looping for three passes
    begin_run(2'b01, 1'b1, 1'b1);
    run_pass("loop1", 0, 0, 1'b1);
    run_pass("loop2", 0, 0, 1'b0);
    run_pass("loop3", 0, 0, 1'b0);
    loop_a = 1'b0;
    repeat (4) @(negedge clk);
    check("loop_done_hold", 64'(o_done), 1);
    check("loop_pcnt_hold", 64'(o_pcnt), 3);
    check("loop_pass_low",  64'(o_pass), 0);

    // Start re-pulsed mid-run (with mode/inject changed) must be ignored
    rm = 2'($urandom_range(3));
    begin_run(rm, 1'b1, 1'b0);
    run_pass("repulse", 300, 0, 1'b1);

    // Fresh start from DONE clears counters, then reset lands mid-READ
    rm = 2'($urandom_range(3));
    begin_run(rm, 1'b0, 1'b0);
    run_pass("abort", 0, depth + 100, 1'b1);
    rm = 2'($urandom_range(3));
    begin_run(rm, 1'b0, 1'b0);
    run_pass("after_rst", 0, 0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      rm = 2'($urandom_range(3));
      ri = 1'($urandom_range(1));
      begin_run(rm, ri, 1'b0);
      run_pass($sformatf("rand%0d_m%0d_i%0d", i, rm, ri), 0, 0, 1'b1);
    end

    // Narrow data, wide address: address-as-data truncates
    sel = 1;
    depth = 1024;
    dw = 8;
    @(negedge clk);
    begin_run(2'b11, 1'b0, 1'b0);
    run_pass("narrow_addr", 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_bist_sdp.md
# ram_bist_sdp

Parametrised built-in self-test for an on-chip simple dual-port RAM. The block writes a selectable pattern to every location through port A, reads it back through port B, and compares each word against a regenerated expected value. It reports pass/fail, the error count and the first failing address, and can loop continuously. It sits in the board bring-up designs behind the differential clock buffer, with its debug outputs wired to an ILA.

## Interface
- `DATA_W`, default 16: RAM word width, from 8 to 64.
- `ADDR_W`, default 9: address width. `DEPTH = 2**ADDR_W`.
- `SEED`, default 1: start value for the incrementing pattern, truncated to `DATA_W`.
- `INJ_ADDR`, default `DEPTH/2`: address corrupted when fault injection is armed.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: run request, sampled in IDLE or DONE only.
- `mode`, input, 2: pattern select, latched on accepted `start`.
- `loop`, input, 1: when set, restart automatically after each pass. Sampled in DONE.
- `inject`, input, 1: arm fault injection, latched on accepted `start`.
- `busy`, output, 1: high in WRITE, READ and DRAIN.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: valid while `done`. High when every pass since `start` had zero errors.
- `err_cnt`, output, 16: saturating mismatch count, cleared on accepted `start`.
- `first_err_addr`, output, `ADDR_W`: address of the first mismatch since `start`.
- `pass_cnt`, output, 16: wrapping count of completed passes, cleared on accepted `start`.
- `dbg_rd_addr`, output, `ADDR_W`: current port-B address, for the ILA.
- `dbg_rd_data`, output, `DATA_W`: current port-B data, for the ILA.

## Operation
- FSM states: IDLE → WRITE → READ → DRAIN → DONE.
  - DONE → WRITE when `start`, or when `loop` is high.
  - DONE → IDLE is never taken. DONE holds until the next run.
- Accepted `start` (in IDLE or DONE):
  - latches `mode` and `inject`;
  - clears `err_cnt`, `first_err_addr` and `pass_cnt`;
  - sets the internal sticky `ok` flag to 1;
  - clears the write address.
- `start` during `busy` is ignored.
- WRITE: one write per cycle at addresses 0 to DEPTH-1, with `wea=1` and `dina = pat(mode, addr)`.
  - When `inject` is latched, the word written at `INJ_ADDR` has bit 0 inverted.
  - After the write at DEPTH-1, go to READ.
- READ: one read per cycle at addresses 0 to DEPTH-1. `wea=0` for the whole state.
- DRAIN: a single cycle in which the last read word is compared.
- Compare: `exp = pat(mode, addr)` is delayed by one cycle to align with `doutb`.
  - On mismatch, `err_cnt` increments and saturates at 0xFFFF.
  - `first_err_addr` is captured on the first mismatch only.
  - `ok` is cleared on any mismatch.
- Entering DONE: `pass_cnt` increments, and `pass = ok`.
- `loop` restart: DONE → WRITE with counters and `ok` retained, so `pass` stays low after any failing pass.
- Pattern function `pat`, with all arithmetic modulo `2**DATA_W`:
  - 00 incrementing: `SEED + addr`.
  - 01 walking ones: `1 << (addr mod DATA_W)`.
  - 10 checkerboard: 0x55… for even addresses, 0xAA… for odd addresses.
  - 11 address-as-data: `addr`, zero-extended, or truncated when `ADDR_W > DATA_W`.
- Reset (async, at any point, mid-run included):
  - FSM goes to IDLE;
  - all outputs and addresses go to 0, `wea` goes to 0;
  - RAM contents are not cleared.

## Timing
- RAM read latency is 1 cycle: `doutb` for an address issued in cycle t is valid in cycle t+1.
- `start` sampled at edge E gives:
  - `busy` = 1 from E+1;
  - DEPTH write cycles, then DEPTH read cycles, then 1 DRAIN cycle;
  - `done` = 1 and `busy` = 0 from edge E + 2·DEPTH + 1, which is cycle 2·DEPTH+2 counting the start cycle.
- `err_cnt` and `first_err_addr` update on the edge that ends the compare cycle, which is 2 edges after the address was issued.
- In `loop` mode, DONE lasts exactly 1 cycle before WRITE.
- Wrap-around: address counters stop at DEPTH-1 and never wrap inside a state. They are reset to 0 on each state entry.
- Simultaneous events: a mismatch on the DRAIN cycle is counted before `pass` is computed.

## Structure
- Package `ram_bist_pkg` holds:
  - the state enum;
  - mode constants `MODE_INC`, `MODE_WALK1`, `MODE_CHK` and `MODE_ADDR`;
  - the function `pat(mode, addr, DATA_W, SEED)`, shared by the write path and the compare path.
- Sub-module `ram_sdp`:
  - parametrised inferred simple dual-port RAM (`DATA_W` × `DEPTH`);
  - ports `clka`, `wea`, `addra`, `dina`, `clkb`, `addrb`, `doutb`;
  - registered output, no reset on the array.
- The top level holds the FSM, address counters, expected-data pipeline and status registers.

## Test plan
All scenarios use `DATA_W=16` and `ADDR_W=9` unless stated otherwise.

1. `mode=00`, `SEED=1`, `start` pulse → `done` after 1026 cycles, `pass=1`, `err_cnt=0`, `pass_cnt=1`. `dbg_rd_data` reads 0x0001 … 0x0200.
2. `inject=1`, `mode=10` → `pass=0`, `err_cnt=1`, `first_err_addr=256`. The data seen at address 256 is 0x5554.
3. `mode=01` with `inject=1` and `loop=1`, run 3 passes → `pass_cnt=3`, `err_cnt=3`, and `pass` stays 0 on every DONE.
4. `start` re-pulsed at cycle 300 of a run → ignored; `done` still arrives at cycle 1026. A later `start` in DONE clears `err_cnt` and `pass_cnt`.
5. `rst_n` asserted during READ → all outputs go to 0 immediately. A following `start` completes normally with `pass=1`.
6. `DATA_W=8`, `ADDR_W=10`, `mode=11` → data truncates to the low 8 bits, so addresses 255 and 256 hold 0xFF and 0x00. Result is `pass=1`.
